// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
// pipe_hazard_ctrl_if
// Interface bundle for the pipeline hazard controller: decode/execute/memory
// hazard inputs and the stall/flush controls returned to the pipeline.
// Optional perf-counter signals exist only when HAZARD_PERF_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if #(
  parameter int REGFILE_ADDR_WIDTH = 5
);
  logic [REGFILE_ADDR_WIDTH-1:0] IF_ID_Rs1_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] IF_ID_Rs2_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] ID_EX_Rd_addr;
  logic                          ID_EX_Mem_rd_en;
  logic                          EX_Branch_taken;
  logic                          MEM_Req;
  logic                          MEM_Ack;
  logic                          PC_stall;
  logic                          IF_ID_stall;
  logic                          IF_ID_flush;
  logic                          ID_EX_stall;
  logic                          ID_EX_flush;
  logic                          EX_MEM_stall;
  logic                          MEM_WB_flush;
  logic                          Mem_timeout;
  logic [1:0]                    Hazard_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]                   Stall_cycles;
  logic [31:0]                   Flush_count;

  modport slave (
    input  IF_ID_Rs1_addr, IF_ID_Rs2_addr, ID_EX_Rd_addr, ID_EX_Mem_rd_en,
           EX_Branch_taken, MEM_Req, MEM_Ack,
    output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_stall, MEM_WB_flush, Mem_timeout, Hazard_state,
           Stall_cycles, Flush_count
  );

  modport master (
    output IF_ID_Rs1_addr, IF_ID_Rs2_addr, ID_EX_Rd_addr, ID_EX_Mem_rd_en,
           EX_Branch_taken, MEM_Req, MEM_Ack,
    input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_stall, MEM_WB_flush, Mem_timeout, Hazard_state,
           Stall_cycles, Flush_count
  );
`else
  modport slave (
    input  IF_ID_Rs1_addr, IF_ID_Rs2_addr, ID_EX_Rd_addr, ID_EX_Mem_rd_en,
           EX_Branch_taken, MEM_Req, MEM_Ack,
    output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_stall, MEM_WB_flush, Mem_timeout, Hazard_state
  );

  modport master (
    output IF_ID_Rs1_addr, IF_ID_Rs2_addr, ID_EX_Rd_addr, ID_EX_Mem_rd_en,
           EX_Branch_taken, MEM_Req, MEM_Ack,
    input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           EX_MEM_stall, MEM_WB_flush, Mem_timeout, Hazard_state
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl
// Stall/flush generator for the 5-stage RV32I pipeline: load-use bubble,
// taken-branch flush and multi-cycle data-memory freeze with timeout trap.
// Optional macro: HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int MAX_WAIT           = 15
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pipe_hazard_ctrl_if.slave    hz
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [REGFILE_ADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TRAP     = 2'b10
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  logic mem_hold;
  logic load_use;
  logic freeze;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush;

  // Prioritised stall/flush decode; reset forces every control low.
  always_comb begin
    mem_hold     = hz.MEM_Req & ~hz.MEM_Ack;
    load_use     = hz.ID_EX_Mem_rd_en & (hz.ID_EX_Rd_addr != ZERO_REG) &
                   ((hz.ID_EX_Rd_addr == hz.IF_ID_Rs1_addr) |
                    (hz.ID_EX_Rd_addr == hz.IF_ID_Rs2_addr));
    freeze       = (state == TRAP) | mem_hold;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (Reset) begin
      pc_stall = 1'b0;
    end else if (freeze) begin
      // Branch and load-use are suppressed; the branch re-evaluates on release.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (hz.EX_Branch_taken) begin
      // Dependent instruction is discarded, so a coincident load-use is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // Memory wait-state FSM; trap taken at equality so wait_cnt never wraps.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_hold) begin
            state    <= MEM_WAIT;
            wait_cnt <= CW'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          // A dropped request releases the pipeline just like an ack.
          if (hz.MEM_Ack | ~hz.MEM_Req) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state     <= TRAP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.PC_stall     = pc_stall;
  assign hz.IF_ID_stall  = if_id_stall;
  assign hz.IF_ID_flush  = if_id_flush;
  assign hz.ID_EX_stall  = id_ex_stall;
  assign hz.ID_EX_flush  = id_ex_flush;
  assign hz.EX_MEM_stall = ex_mem_stall;
  assign hz.MEM_WB_flush = mem_wb_flush;
  assign hz.Mem_timeout  = timeout_q & ~Reset;
  assign hz.Hazard_state = Reset ? 2'b00 : state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Saturating event counters for stalled and flushed cycles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hz.Stall_cycles = stall_cnt;
  assign hz.Flush_count  = flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (MAX_WAIT=4). Each row drives one
// cycle of inputs and queues the expected outputs; the queue is popped and
// compared on the falling edge of that cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  pipe_hazard_ctrl_if #(.REGFILE_ADDR_WIDTH(5)) hz ();

  pipe_hazard_ctrl #(.REGFILE_ADDR_WIDTH(5), .MAX_WAIT(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hz    (hz)
  );

  // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
  //  EX_MEM_stall, MEM_WB_flush, Mem_timeout, Hazard_state[1:0]}
  localparam logic [9:0] ZERO = 10'b0000000_0_00;
  localparam logic [9:0] FRZ  = 10'b1101011_0_00;
  localparam logic [9:0] LU   = 10'b1100100_0_00;
  localparam logic [9:0] BR   = 10'b0010100_0_00;
  localparam logic [9:0] ST_W = 10'b0000000_0_01;
  localparam logic [9:0] TRP  = 10'b1101011_1_10;

  typedef struct {
    logic       rst;
    logic       req;
    logic       ack;
    logic       br;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [9:0] exp;
  } row_t;

  logic [9:0] sb[$];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  function automatic row_t mk(logic rst, logic req, logic ack, logic br,
                              logic ld, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [9:0] exp);
    row_t r;
    r.rst = rst; r.req = req; r.ack = ack; r.br = br; r.ld = ld;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.exp = exp;
    return r;
  endfunction

  function automatic logic [9:0] obs();
    return {hz.PC_stall, hz.IF_ID_stall, hz.IF_ID_flush, hz.ID_EX_stall,
            hz.ID_EX_flush, hz.EX_MEM_stall, hz.MEM_WB_flush,
            hz.Mem_timeout, hz.Hazard_state};
  endfunction

  // Drive one cycle of stimulus and queue its expected outputs.
  task automatic apply(input row_t r);
    Reset              = r.rst;
    hz.MEM_Req         = r.req;
    hz.MEM_Ack         = r.ack;
    hz.EX_Branch_taken = r.br;
    hz.ID_EX_Mem_rd_en = r.ld;
    hz.ID_EX_Rd_addr   = r.rd;
    hz.IF_ID_Rs1_addr  = r.rs1;
    hz.IF_ID_Rs2_addr  = r.rs2;
    sb.push_back(r.exp);
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [9:0] e, got;
    rows.push_back(mk(1, 1, 0, 1, 1, 5, 5, 5, ZERO));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL reset[%0d]: got %b expected %b", i, got, e);
      end else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [9:0] e, got;
    rows.push_back(mk(0, 0, 0, 0, 1, 5, 0, 5, LU));    // rs2 match
    rows.push_back(mk(0, 0, 0, 0, 0, 5, 0, 5, ZERO));  // bubble lasts one cycle
    rows.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, ZERO));  // rd = x0
    rows.push_back(mk(0, 0, 0, 0, 1, 7, 7, 3, LU));    // rs1 match
    rows.push_back(mk(0, 0, 0, 0, 1, 9, 7, 3, ZERO));  // load, no match
    rows.push_back(mk(0, 0, 0, 0, 0, 7, 7, 7, ZERO));  // match but not a load
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, got, e);
      end else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [9:0] e, got;
    rows.push_back(mk(0, 0, 0, 1, 1, 5, 0, 5, BR));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, BR));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL branch[%0d]: got %b expected %b", i, got, e);
      end else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    row_t rows[$];
    logic [9:0] e, got;
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ | ST_W));
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ | ST_W));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, ST_W));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    // wait masking a branch and a load-use
    rows.push_back(mk(0, 1, 0, 1, 1, 5, 5, 0, FRZ));
    rows.push_back(mk(0, 1, 0, 1, 1, 5, 5, 0, FRZ | ST_W));
    rows.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, BR | ST_W));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    // request withdrawn mid-wait releases like an ack
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ));
    rows.push_back(mk(0, 0, 0, 0, 1, 4, 4, 0, LU | ST_W));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL mem_wait[%0d]: got %b expected %b", i, got, e);
      end else passed++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [9:0] e, got;
    // Ack in the last allowed cycle: accepted, no trap.
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ));
    for (int k = 0; k < 3; k++) rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ | ST_W));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, ST_W));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    // Five unacked cycles: trap from cycle 6, ack ignored afterwards.
    rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ));
    for (int k = 0; k < 4; k++) rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, FRZ | ST_W));
    rows.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, TRP));
    rows.push_back(mk(0, 0, 0, 0, 1, 3, 3, 3, TRP));
    rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, BR));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge Clk);
      got = obs();
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL timeout[%0d]: got %b expected %b", i, got, e);
      end else passed++;
      @(posedge Clk); #1;
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    row_t rows[$];
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, ZERO));
    for (int k = 0; k < 3; k++) rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 0, 1, 6, 6, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, ZERO));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    foreach (rows[i]) begin
      apply(rows[i]);
      void'(sb.pop_front());
      @(posedge Clk); #1;
    end
    checks++;
    if (hz.Stall_cycles !== 32'd4) begin
      fails++;
      $display("FAIL stall_cycles: got %0d expected 4", hz.Stall_cycles);
    end else passed++;
    checks++;
    if (hz.Flush_count !== 32'd2) begin
      fails++;
      $display("FAIL flush_count: got %0d expected 2", hz.Flush_count);
    end else passed++;
  endtask
`endif

  initial begin
    Reset = 1'b1;
    hz.MEM_Req = 1'b0; hz.MEM_Ack = 1'b0; hz.EX_Branch_taken = 1'b0;
    hz.ID_EX_Mem_rd_en = 1'b0; hz.ID_EX_Rd_addr = '0;
    hz.IF_ID_Rs1_addr = '0; hz.IF_ID_Rs2_addr = '0;
    @(posedge Clk); #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the forwarding unit and generates every stall and flush control for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It handles three cases that forwarding cannot resolve:

- **Load-use hazards:** one-cycle bubble.
- **Taken branches and jumps:** flush of the two younger stages.
- **Multi-cycle data-memory accesses:** full freeze with a wait-state FSM and a timeout trap.

## Interface

**Parameters**

- `REGFILE_ADDR_WIDTH`, 5, register address width.
- `MAX_WAIT`, 15, maximum additional unacknowledged memory-wait cycles before trapping. Must be ≥1.

**Ports**

- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `IF_ID_Rs1_addr`  in  `REGFILE_ADDR_WIDTH`  rs1 of the instruction being decoded.
- `IF_ID_Rs2_addr`  in  `REGFILE_ADDR_WIDTH`  rs2 of the instruction being decoded.
- `ID_EX_Rd_addr`  in  `REGFILE_ADDR_WIDTH`  rd of the instruction in ID/EX.
- `ID_EX_Mem_rd_en`  in  1  the instruction in ID/EX is a load.
- `EX_Branch_taken`  in  1  branch/jump resolved taken in EX this cycle.
- `MEM_Req`  in  1  MEM stage holds a valid data-memory access.
- `MEM_Ack`  in  1  data memory completes the access this cycle.
- `PC_stall`  out  1  hold PC.
- `IF_ID_stall`  out  1  hold IF/ID.
- `IF_ID_flush`  out  1  clear IF/ID to NOP.
- `ID_EX_stall`  out  1  hold ID/EX.
- `ID_EX_flush`  out  1  clear ID/EX to NOP.
- `EX_MEM_stall`  out  1  hold EX/MEM.
- `MEM_WB_flush`  out  1  insert a bubble into MEM/WB.
- `Mem_timeout`  out  1  sticky memory-timeout trap flag.
- `Hazard_state`  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 TRAP.

## Operation

**Signal definitions**

- `mem_hold = MEM_Req & ~MEM_Ack`.
- `load_use = ID_EX_Mem_rd_en & (ID_EX_Rd_addr != 0) & (ID_EX_Rd_addr == IF_ID_Rs1_addr | ID_EX_Rd_addr == IF_ID_Rs2_addr)`.

**Output priority (highest first), evaluated combinationally each cycle**

1. **TRAP state:** `PC_stall`, `IF_ID_stall`, `ID_EX_stall`, `EX_MEM_stall` and `MEM_WB_flush` are all 1. Both flush outputs are 0. `MEM_Ack` is ignored.
2. **`mem_hold` in RUN or MEM_WAIT:** same freeze as TRAP. Branch and load-use responses are suppressed. The branch stays in EX and is re-evaluated after release.
3. **`EX_Branch_taken`:** `IF_ID_flush=1` and `ID_EX_flush=1`. Any load-use in the same cycle is ignored, because the dependent instruction is discarded.
4. **`load_use`:** `PC_stall=1`, `IF_ID_stall=1`, `ID_EX_flush=1`.
5. Otherwise all stall and flush outputs are 0.

**FSM**

- **RUN:**
  - If `mem_hold`, go to MEM_WAIT and set `wait_cnt` to 1.
  - Otherwise stay in RUN with `wait_cnt` at 0.
- **MEM_WAIT:**
  - If `MEM_Ack`, go to RUN and clear `wait_cnt` to 0.
  - Else if `wait_cnt == MAX_WAIT`, go to TRAP and set `Mem_timeout` to 1.
  - Else increment `wait_cnt`.
- **TRAP:** absorbing. Only `Reset` exits it.
- **`MEM_Req` dropping while in MEM_WAIT:** treated as `Ack`; the FSM returns to RUN.

**Widths**

- `wait_cnt` is `$clog2(MAX_WAIT+1)` bits.
- `wait_cnt` never wraps, because the trap is taken at equality.

## Timing

- **Stall and flush outputs:** combinational from the current inputs and state, with zero latency. The pipeline registers consume them at the same edge.
- **`Hazard_state` and `Mem_timeout`:** registered; they change one cycle after the triggering condition.
- **Timeout point:** TRAP is reached after `MAX_WAIT+1` consecutive unacknowledged cycles. An `Ack` arriving in the last of those cycles is accepted and no trap occurs.
- **Load-use bubble:** exactly one cycle. The next cycle the load is in EX and `load_use` deasserts naturally.
- **Reset:**
  - While `Reset` is high, every output is 0.
  - At the edge: state becomes RUN, `wait_cnt` becomes 0, `Mem_timeout` becomes 0.
  - A reset asserted mid-wait or in TRAP takes effect at that edge regardless of `MEM_Ack`.

## Configuration

- `HAZARD_PERF_CNT_EN` defined: two extra outputs are added.
  - `Stall_cycles` (out, 32): increments on every cycle with `PC_stall=1`.
  - `Flush_count` (out, 32): increments on every cycle with `IF_ID_flush=1`.
  - Both are zeroed by `Reset` and saturate at all-ones.
- Not defined: the ports and counters are absent, and the remaining behaviour is identical.

## Test plan

- **Load-use:** `ID_EX_Mem_rd_en=1`, `ID_EX_Rd_addr=5`, `IF_ID_Rs2_addr=5` for 1 cycle.
  - Required: `PC_stall=IF_ID_stall=ID_EX_flush=1` that cycle only.
  - With `Rd_addr=0`, all outputs must be 0.
- **Branch vs load-use:** `EX_Branch_taken=1` together with the load-use from the previous case.
  - Required: `IF_ID_flush=ID_EX_flush=1`, `PC_stall=0`.
- **Memory wait:** `MEM_Req=1`, `MEM_Ack=0` for 3 cycles, then `Ack=1`.
  - Required: freeze outputs high for 3 cycles; `Hazard_state=01` for cycles 2–4; RUN after the ack edge.
- **Wait masking a branch:** `mem_hold` held for 2 cycles with `EX_Branch_taken=1`.
  - Required: no flush until `MEM_Ack`; flush in the first cycle after release.
- **Timeout, `MAX_WAIT=4`:**
  - `Req` with no `Ack` for 5 cycles: `Mem_timeout=1` and `Hazard_state=10` from cycle 6, then `Ack` is ignored.
  - `Ack` in cycle 5 instead: no trap.
  - `Reset` clears the trap.
- **`HAZARD_PERF_CNT_EN`:** 3 wait cycles plus 1 load-use plus 2 branches.
  - Required: `Stall_cycles=4`, `Flush_count=2`.
